// File: rtl/sram_banked_rw_pkg.sv
// Shared helpers for the banked SRAM: byte width and elaboration-time sizing functions.
package sram_banked_rw_pkg;

  localparam int BYTE_W = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Keeps derived vector widths at least one bit wide.
  function automatic int max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/sram_bank_mem.sv
// One SRAM bank: ROWS x WORD_WIDTH, byte-enable write, registered read.
// Only touched when i_en is high, so an idle bank draws no access power.
module sram_bank_mem
  import sram_banked_rw_pkg::*;
#(
  parameter int ROWS       = 2048,
  parameter int ROW_W      = 11,
  parameter int WORD_WIDTH = 16,
  parameter int BE_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ROW_W-1:0]      i_row,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  input  logic [BE_WIDTH-1:0]   i_be,
  output logic [WORD_WIDTH-1:0] o_rdata
);

  logic [WORD_WIDTH-1:0] mem_q [ROWS];
  logic [WORD_WIDTH-1:0] rdata_q;

  // Single port: either merge enabled bytes into the row or capture the row into the read register.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (i_be[b]) begin
            mem_q[i_row][BYTE_W*b +: BYTE_W] <= i_wdata[BYTE_W*b +: BYTE_W];
          end
        end
      end else begin
        rdata_q <= mem_q[i_row];
      end
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/sram_banked_rw.sv
// Banked single-port SRAM with valid/ready request and response channels.
// Request channel: a request transfers on a rising edge where i_req_valid and o_req_ready are both 1;
// o_req_ready depends only on the registered credit count. Response channel: a response transfers on
// a rising edge where o_rsp_valid and i_rsp_ready are both 1; the head entry is held until it does.
module sram_banked_rw
  import sram_banked_rw_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_DEPTH = 4096,
  parameter int WORD_WIDTH = 16,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_we,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic [WORD_WIDTH-1:0]          i_wdata,
  input  logic [WORD_WIDTH/BYTE_W-1:0]   i_be,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [WORD_WIDTH-1:0]          o_rsp_data,
  output logic                           o_rsp_err
);

  localparam int BE_WIDTH  = WORD_WIDTH / BYTE_W;
  localparam int RSP_DEPTH = RD_LATENCY + 1;
  localparam int ROWS      = WORD_DEPTH / NUM_BANKS;
  localparam int ROW_W     = max1(clog2(ROWS));
  localparam int BANK_W    = max1(clog2(NUM_BANKS));
  localparam int CNT_W     = clog2(RSP_DEPTH + 1);
  localparam int PTR_W     = max1(clog2(RSP_DEPTH));

  // Illegal parameter combinations stop elaboration.
  if (WORD_WIDTH % BYTE_W != 0) begin : g_bad_word_width
    $error("WORD_WIDTH must be a multiple of 8");
  end
  if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("NUM_BANKS must be a power of 2");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..4");
  end
  if (WORD_DEPTH % NUM_BANKS != 0 || WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("WORD_DEPTH must be a multiple of NUM_BANKS and fit the address");
  end

  // Request decode
  logic                  req_acc;
  logic                  rd_acc;
  logic                  in_range;
  logic [BANK_W-1:0]     req_bank;
  logic [ROW_W-1:0]      req_row;

  // Read pipeline: valid and error shift registers, bank select for the stage-0 mux
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [RD_LATENCY-1:0] perr_q, perr_d;
  logic [BANK_W-1:0]     psel_q, psel_d;
  logic [WORD_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [WORD_WIDTH-1:0] rd_mux;
  logic [WORD_WIDTH-1:0] fifo_wdata;

  // Response FIFO and credits
  logic [WORD_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  fifo_err_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fifo_push;
  logic                  fifo_pop;

  // Bank is the low address bits and row the rest; both are plain bit selects since NUM_BANKS is 2**n.
  always_comb begin
    req_acc  = i_req_valid & o_req_ready;
    rd_acc   = req_acc & ~i_we;
    in_range = (32'(i_addr) < 32'(WORD_DEPTH));
    req_bank = BANK_W'(32'(i_addr) % 32'(NUM_BANKS));
    req_row  = ROW_W'(32'(i_addr) / 32'(NUM_BANKS));
  end

  // Only the addressed bank is enabled; out-of-range accesses enable none, so writes there are dropped.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_en;
    assign bank_en = req_acc & in_range & (req_bank == BANK_W'(b));
    sram_bank_mem #(
      .ROWS       (ROWS),
      .ROW_W      (ROW_W),
      .WORD_WIDTH (WORD_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
    ) u_mem (
      .clk     (clk),
      .i_en    (bank_en),
      .i_we    (i_we),
      .i_row   (req_row),
      .i_wdata (i_wdata),
      .i_be    (i_be),
      .o_rdata (bank_rdata[b])
    );
  end

  // Stage 0 selects the bank that was read; an out-of-range read is forced to zero here.
  always_comb begin
    rd_mux = perr_q[0] ? '0 : bank_rdata[psel_q];
  end

  // Extra data stages so the word reaches the FIFO exactly RD_LATENCY edges after accept.
  if (RD_LATENCY == 1) begin : g_no_dpipe
    assign fifo_wdata = rd_mux;
  end else begin : g_dpipe
    logic [WORD_WIDTH-1:0] dpipe_q [RD_LATENCY-1];
    // Shift the muxed read data down the pipe; validity travels in pv_q.
    always_ff @(posedge clk) begin
      dpipe_q[0] <= rd_mux;
      for (int k = 1; k < RD_LATENCY - 1; k++) begin
        dpipe_q[k] <= dpipe_q[k-1];
      end
    end
    assign fifo_wdata = dpipe_q[RD_LATENCY-2];
  end

  assign fifo_push   = pv_q[RD_LATENCY-1];
  assign o_rsp_valid = (fill_q != '0);
  assign fifo_pop    = o_rsp_valid & i_rsp_ready;
  assign o_req_ready = (cnt_q < CNT_W'(RSP_DEPTH));
  assign o_rsp_data  = o_rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_rsp_err   = o_rsp_valid & fifo_err_q[rd_ptr_q];

  // Next-state for the read pipe, FIFO pointers/fill and the credit counter.
  always_comb begin
    pv_d     = (pv_q << 1) | RD_LATENCY'(rd_acc);
    perr_d   = (perr_q << 1) | RD_LATENCY'(rd_acc & ~in_range);
    psel_d   = rd_acc ? req_bank : psel_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    if (fifo_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (fifo_push && !fifo_pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!fifo_push && fifo_pop) begin
      fill_d = fill_q - 1'b1;
    end
    // A credit is held from read accept until that response is popped.
    if (rd_acc && !fifo_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!rd_acc && fifo_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state; reset discards every in-flight and buffered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q     <= '0;
      perr_q   <= '0;
      psel_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
    end else begin
      pv_q     <= pv_d;
      perr_q   <= perr_d;
      psel_q   <= psel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are only observed while fill_q says the slot is live.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= fifo_wdata;
      fifo_err_q[wr_ptr_q]  <= perr_q[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_sram_banked_rw.sv
// Directed bench for sram_banked_rw (WORD_DEPTH=4000, RD_LATENCY=2, two banks).
module tb_sram_banked_rw;

  localparam int AW    = 12;
  localparam int DEPTH = 4000;
  localparam int WW    = 16;
  localparam int NB    = 2;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [WW-1:0] i_wdata;
  logic [1:0]    i_be;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [WW-1:0] o_rsp_data;
  logic          o_rsp_err;

  sram_banked_rw #(
    .ADDR_WIDTH (AW),
    .WORD_DEPTH (DEPTH),
    .WORD_WIDTH (WW),
    .NUM_BANKS  (NB),
    .RD_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_be        (i_be),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [WW:0] exp_q[$];   // {err, data}
  int acc_cycle = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: samples mid-low-phase so driver updates at the falling edge have settled.
  always begin
    logic [WW:0] e;
    @(negedge clk);
    #2;
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL rsp_unexpected: got data 0x%0h err %0b, expected no response", o_rsp_data, o_rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(o_rsp_data), 32'(e[WW-1:0]));
        check("rsp_err", 32'(o_rsp_err), 32'(e[WW]));
      end
    end
  end

  // ---------------- driver tasks (called just after a falling edge) ----------------
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                       input logic [1:0] be, input logic [WW:0] exp);
    int guard;
    guard = 0;
    i_req_valid = 1'b1;
    i_we        = we;
    i_addr      = addr;
    i_wdata     = wdata;
    i_be        = be;
    while (!o_req_ready && guard < 40) begin
      stall_cnt++;
      @(negedge clk);
      guard++;
    end
    if (!o_req_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL req_timeout: o_req_ready stayed 0, expected 1 within 40 cycles");
    end else begin
      if (!we) exp_q.push_back(exp);
      acc_cycle = cycle + 1;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [WW-1:0] data, input logic [1:0] be);
    issue(1'b1, addr, data, be, '0);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic err, input logic [WW-1:0] data);
    issue(1'b0, addr, '0, 2'b00, {err, data});
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    i_we        = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || o_rsp_valid) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [WW-1:0] bp_data [4];
  int n_acc;
  int start_cycle;
  int stale;
  int g;

  initial begin
    bp_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    i_req_valid = 1'b0;
    i_we        = 1'b0;
    i_addr      = '0;
    i_wdata     = '0;
    i_be        = '0;
    i_rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(o_req_ready), 32'd1);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(o_rsp_data), 32'd0);
    check("reset_rsp_err", 32'(o_rsp_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full-word write, read back with latency measurement
    wr(12'h010, 16'hBEEF, 2'b11);
    rd(12'h010, 1'b0, 16'hBEEF);
    idle();
    g = 0;
    while (!o_rsp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("rd_latency", 32'(cycle - acc_cycle), 32'(LAT));
    drain();

    // Byte enables, including all-zero no-op and low-byte-only
    wr(12'h005, 16'h1234, 2'b11);
    wr(12'h005, 16'hAB00, 2'b10);
    rd(12'h005, 1'b0, 16'hAB34);
    wr(12'h005, 16'hFFFF, 2'b00);
    rd(12'h005, 1'b0, 16'hAB34);
    wr(12'h005, 16'h77CD, 2'b01);
    rd(12'h005, 1'b0, 16'hABCD);
    idle();
    drain();

    // Backpressure: only RSP_DEPTH=3 reads may be outstanding
    for (int k = 0; k < 4; k++) wr(12'h020 + 12'(k), bp_data[k], 2'b11);
    idle();
    i_rsp_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      i_req_valid = 1'b1;
      i_we        = 1'b0;
      i_addr      = 12'h020 + 12'(n_acc);
      if (o_req_ready && n_acc < 4) begin
        exp_q.push_back({1'b0, bp_data[n_acc]});
        n_acc++;
      end
      @(negedge clk);
    end
    idle();
    check("bp_accepts", 32'(n_acc), 32'd3);
    check("bp_ready_low", 32'(o_req_ready), 32'd0);
    check("bp_head_valid", 32'(o_rsp_valid), 32'd1);
    check("bp_head_data", 32'(o_rsp_data), 32'h1111);
    repeat (3) @(negedge clk);
    check("bp_head_hold", 32'(o_rsp_data), 32'h1111);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_return", 32'(o_req_ready), 32'd1);
    drain();

    // Out of range: writes dropped, reads flagged with zero data
    wr(12'hFA0, 16'h5A5A, 2'b11);
    wr(12'hF9F, 16'h7777, 2'b11);
    rd(12'hFA0, 1'b1, 16'h0000);
    rd(12'hF9F, 1'b0, 16'h7777);
    rd(12'hFFF, 1'b1, 16'h0000);
    rd(12'h010, 1'b0, 16'hBEEF);
    idle();
    drain();

    // Bank interleave: write/read pairs back to back, one accept every cycle
    stall_cnt   = 0;
    start_cycle = cycle;
    for (int k = 0; k < 8; k++) begin
      wr(12'(k), 16'hC3A0 + 16'(k), 2'b11);
      rd(12'(k), 1'b0, 16'hC3A0 + 16'(k));
    end
    idle();
    check("il_stalls", 32'(stall_cnt), 32'd0);
    check("il_cycles", 32'(cycle - start_cycle), 32'd16);
    drain();

    // Reset in the middle of a burst of three reads
    i_rsp_ready = 1'b0;
    rd(12'h010, 1'b0, 16'hBEEF);
    rd(12'h005, 1'b0, 16'hABCD);
    rd(12'h020, 1'b0, 16'h1111);
    idle();
    check("pre_rst_valid", 32'(o_rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    @(negedge clk);
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    rst = 1'b0;
    i_rsp_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_rsp_valid) stale++;
    end
    check("rst_no_stale", 32'(stale), 32'd0);
    rd(12'h021, 1'b0, 16'h2222);
    idle();
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
